// File: rtl/bp_be_pipe_int_staged.sv
// Pipelined integer execution pipe: ALU, link value and branch resolution are
// computed in stage 0, then carried through stages_p registered stages with stall/flush.
module bp_be_pipe_int_staged #(
    parameter int vaddr_width_p = 39,
    parameter int data_width_p  = 64,
    parameter int stages_p      = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     flush_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [3:0]               fu_op_i,
    input  logic                     opw_v_i,
    input  logic                     src1_sel_i,
    input  logic                     src2_sel_i,
    input  logic                     baddr_sel_i,
    input  logic                     result_sel_i,
    input  logic                     br_v_i,
    input  logic                     jmp_v_i,
    input  logic [vaddr_width_p-1:0] pc_i,
    input  logic [data_width_p-1:0]  rs1_i,
    input  logic [data_width_p-1:0]  rs2_i,
    input  logic [data_width_p-1:0]  imm_i,
    input  logic [vaddr_width_p-1:0] pred_tgt_i,
    output logic                     v_o,
    input  logic                     ready_i,
    output logic [data_width_p-1:0]  data_o,
    output logic [vaddr_width_p-1:0] br_tgt_o,
    output logic                     taken_o,
    output logic                     mispredict_o
);
    localparam int W = data_width_p;
    localparam int V = vaddr_width_p;

    logic [W-1:0] w_pc_ext, w_src1, w_src2, w_base, w_link, w_alu, w_data;
    logic [5:0]   w_shamt;
    logic [31:0]  w_word;
    logic         w_eq, w_lt, w_ltu, w_word_op, w_taken, w_mis, w_adv;
    logic [V-1:0] w_tgt;

    logic [stages_p-1:0] r_v;
    logic [stages_p-1:0] r_taken;
    logic [stages_p-1:0] r_mis;
    logic [W-1:0]        r_data [stages_p];
    logic [V-1:0]        r_tgt  [stages_p];

    assign w_pc_ext  = {{(W-V){pc_i[V-1]}}, pc_i};
    assign w_src1    = src1_sel_i ? w_pc_ext : rs1_i;
    assign w_src2    = src2_sel_i ? imm_i : rs2_i;
    assign w_base    = baddr_sel_i ? w_src1 : w_pc_ext;
    assign w_link    = w_pc_ext + W'(4);
    assign w_shamt   = opw_v_i ? {1'b0, w_src2[4:0]} : w_src2[5:0];
    assign w_eq      = (w_src1 == w_src2);
    assign w_lt      = ($signed(w_src1) < $signed(w_src2));
    assign w_ltu     = (w_src1 < w_src2);
    // Only add/sub/shifts have word forms; compares and logic ignore opw_v_i.
    assign w_word_op = opw_v_i & (fu_op_i inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7});

    always_comb begin
        w_word = '0;
        case (fu_op_i)
            4'd0:    w_word = w_src1[31:0] + w_src2[31:0];
            4'd1:    w_word = w_src1[31:0] - w_src2[31:0];
            4'd2:    w_word = w_src1[31:0] << w_shamt[4:0];
            4'd6:    w_word = w_src1[31:0] >> w_shamt[4:0];
            4'd7:    w_word = $signed(w_src1[31:0]) >>> w_shamt[4:0];
            default: w_word = '0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (fu_op_i)
            4'd0:    w_alu = w_src1 + w_src2;
            4'd1:    w_alu = w_src1 - w_src2;
            4'd2:    w_alu = w_src1 << w_shamt;
            4'd3:    w_alu = {{(W-1){1'b0}}, w_lt};
            4'd4:    w_alu = {{(W-1){1'b0}}, w_ltu};
            4'd5:    w_alu = w_src1 ^ w_src2;
            4'd6:    w_alu = w_src1 >> w_shamt;
            4'd7:    w_alu = $signed(w_src1) >>> w_shamt;
            4'd8:    w_alu = w_src1 | w_src2;
            4'd9:    w_alu = w_src1 & w_src2;
            4'd10:   w_alu = {{(W-1){1'b0}}, w_eq};
            4'd11:   w_alu = {{(W-1){1'b0}}, ~w_eq};
            4'd12:   w_alu = {{(W-1){1'b0}}, w_lt};
            4'd13:   w_alu = {{(W-1){1'b0}}, ~w_lt};
            4'd14:   w_alu = {{(W-1){1'b0}}, w_ltu};
            default: w_alu = {{(W-1){1'b0}}, ~w_ltu};
        endcase
        if (w_word_op) begin
            w_alu = {{(W-32){w_word[31]}}, w_word};
        end
    end

    // Targets are formed at full data width and then truncated, so overflow wraps.
    assign w_taken = jmp_v_i | (br_v_i & w_alu[0]);
    assign w_tgt   = w_taken ? V'(w_base + imm_i) : V'(w_link);
    assign w_mis   = (br_v_i | jmp_v_i) & (w_tgt != pred_tgt_i);
    assign w_data  = result_sel_i ? w_link : w_alu;

    assign v_o     = r_v[stages_p-1];
    assign w_adv   = ~v_o | ready_i;
    assign ready_o = w_adv;

    assign data_o       = r_data[stages_p-1];
    assign br_tgt_o     = r_tgt[stages_p-1];
    assign taken_o      = r_taken[stages_p-1];
    assign mispredict_o = r_mis[stages_p-1];

    // The whole pipe moves together; flush only kills valid bits.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v     <= '0;
            r_taken <= '0;
            r_mis   <= '0;
            for (int i = 0; i < stages_p; i++) begin
                r_data[i] <= '0;
                r_tgt[i]  <= '0;
            end
        end else begin
            if (w_adv) begin
                r_v[0]     <= v_i;
                r_data[0]  <= w_data;
                r_tgt[0]   <= w_tgt;
                r_taken[0] <= w_taken;
                r_mis[0]   <= w_mis;
                for (int i = 1; i < stages_p; i++) begin
                    r_v[i]     <= r_v[i-1];
                    r_data[i]  <= r_data[i-1];
                    r_tgt[i]   <= r_tgt[i-1];
                    r_taken[i] <= r_taken[i-1];
                    r_mis[i]   <= r_mis[i-1];
                end
            end
            if (flush_i) begin
                r_v <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bp_be_pipe_int_staged.sv
// Bench for bp_be_pipe_int_staged: directed vector table, stall/flush/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_bp_be_pipe_int_staged;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [3:0]  op;
        logic        opw, s1, s2, bsel, rsel, br, jmp;
        logic [38:0] pc;
        logic [63:0] rs1, rs2, imm;
        logic [38:0] pred;
    } op_t;

    typedef struct packed {
        logic [63:0] data;
        logic [38:0] tgt;
        logic        taken, mis;
    } res_t;

    typedef struct packed {
        op_t  in;
        res_t exp;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        v_i = 1'b0;
    logic        ready_i = 1'b0;
    op_t         cur = '0;
    logic        ready_o, v_o, taken_o, mispredict_o;
    logic [63:0] data_o;
    logic [38:0] br_tgt_o;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    vec_t vecs[16];

    always #5 clk_i = ~clk_i;

    bp_be_pipe_int_staged #(.vaddr_width_p(39), .data_width_p(64), .stages_p(STAGES)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i), .v_i(v_i), .ready_o(ready_o),
        .fu_op_i(cur.op), .opw_v_i(cur.opw), .src1_sel_i(cur.s1), .src2_sel_i(cur.s2),
        .baddr_sel_i(cur.bsel), .result_sel_i(cur.rsel), .br_v_i(cur.br), .jmp_v_i(cur.jmp),
        .pc_i(cur.pc), .rs1_i(cur.rs1), .rs2_i(cur.rs2), .imm_i(cur.imm), .pred_tgt_i(cur.pred),
        .v_o(v_o), .ready_i(ready_i), .data_o(data_o), .br_tgt_o(br_tgt_o),
        .taken_o(taken_o), .mispredict_o(mispredict_o)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t e);
        chk({tag, "_data"}, 128'(data_o), 128'(e.data));
        chk({tag, "_tgt"}, 128'(br_tgt_o), 128'(e.tgt));
        chk({tag, "_taken"}, 128'(taken_o), 128'(e.taken));
        chk({tag, "_mis"}, 128'(mispredict_o), 128'(e.mis));
    endtask

    // Reference: architectural meaning of each op, no pipeline detail.
    function automatic res_t model(input op_t o);
        res_t        r;
        logic [63:0] pcx, a, b, alu, base;
        logic [31:0] w;
        logic        word;
        int          sh;
        pcx  = {{25{o.pc[38]}}, o.pc};
        a    = o.s1 ? pcx : o.rs1;
        b    = o.s2 ? o.imm : o.rs2;
        base = o.bsel ? a : pcx;
        word = o.opw && (o.op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7});
        sh   = word ? int'(b[4:0]) : int'(b[5:0]);
        case (o.op)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a << sh;
            4'd3:    alu = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd4:    alu = (a < b) ? 64'd1 : 64'd0;
            4'd5:    alu = a ^ b;
            4'd6:    alu = a >> sh;
            4'd7:    alu = $signed(a) >>> sh;
            4'd8:    alu = a | b;
            4'd9:    alu = a & b;
            4'd10:   alu = (a == b) ? 64'd1 : 64'd0;
            4'd11:   alu = (a != b) ? 64'd1 : 64'd0;
            4'd12:   alu = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd13:   alu = ($signed(a) >= $signed(b)) ? 64'd1 : 64'd0;
            4'd14:   alu = (a < b) ? 64'd1 : 64'd0;
            default: alu = (a >= b) ? 64'd1 : 64'd0;
        endcase
        if (word) begin
            case (o.op)
                4'd0:    w = a[31:0] + b[31:0];
                4'd1:    w = a[31:0] - b[31:0];
                4'd2:    w = a[31:0] << sh;
                4'd6:    w = a[31:0] >> sh;
                default: w = $signed(a[31:0]) >>> sh;
            endcase
            alu = {{32{w[31]}}, w};
        end
        r.taken = o.jmp || (o.br && alu[0]);
        r.tgt   = r.taken ? 39'(base + o.imm) : 39'(pcx + 64'd4);
        r.mis   = (o.br || o.jmp) && (r.tgt != o.pred);
        r.data  = o.rsel ? pcx + 64'd4 : alu;
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.op = 4'($urandom_range(0, 15));
        {o.opw, o.s1, o.s2, o.bsel, o.rsel} = 5'($urandom());
        o.br   = ($urandom_range(0, 2) == 0);
        o.jmp  = !o.br && ($urandom_range(0, 4) == 0);
        o.pc   = 39'({$urandom(), $urandom()});
        o.rs1  = {$urandom(), $urandom()};
        o.rs2  = ($urandom_range(0, 3) == 0) ? o.rs1 : {$urandom(), $urandom()};
        o.imm  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 4095)) : {$urandom(), $urandom()};
        o.pred = ($urandom_range(0, 1) == 0) ? 39'(o.pc + 39'd4) : 39'({$urandom(), $urandom()});
        return o;
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [6:0] fl, input logic [38:0] pc,
                                input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                                input logic [38:0] pred, input logic [63:0] data, input logic [38:0] tgt,
                                input logic taken, input logic mis);
        vec_t v;
        v.in.op = op;
        {v.in.opw, v.in.s1, v.in.s2, v.in.bsel, v.in.rsel, v.in.br, v.in.jmp} = fl;
        v.in.pc = pc; v.in.rs1 = rs1; v.in.rs2 = rs2; v.in.imm = imm; v.in.pred = pred;
        v.exp.data = data; v.exp.tgt = tgt; v.exp.taken = taken; v.exp.mis = mis;
        return v;
    endfunction

    // One clock with the current inputs: scoreboard handshakes, then advance.
    task automatic cyc();
        res_t e;
        #1;
        chk("ready_o", 128'(ready_o), 128'(!v_o || ready_i));
        if (v_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output: got v_o=1 data=%h, required no pending op", data_o);
            end else begin
                e = exp_q.pop_front();
                $display("out data=%h tgt=%h taken=%b mis=%b", data_o, br_tgt_o, taken_o, mispredict_o);
                cmp_res("sb", e);
            end
        end
        if (v_i && ready_o && !flush_i) exp_q.push_back(model(cur));
        if (flush_i) exp_q.delete();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        // flag order: opw s1 s2 bsel rsel br jmp
        vecs[0]  = mk(4'd0,  7'b0000000, 39'h100, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 39'h0,
                      64'd2, 39'h104, 1'b0, 1'b0);
        vecs[1]  = mk(4'd0,  7'b1000000, 39'h200, 64'h7FFF_FFFF, 64'd1, 64'd0, 39'h0,
                      64'hFFFF_FFFF_8000_0000, 39'h204, 1'b0, 1'b0);
        vecs[2]  = mk(4'd7,  7'b0000000, 39'h300, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 39'h0,
                      64'hFFFF_FFFF_FFFF_FFFF, 39'h304, 1'b0, 1'b0);
        vecs[3]  = mk(4'd10, 7'b0000010, 39'h1000, 64'd7, 64'd7, 64'h20, 39'h1004,
                      64'd1, 39'h1020, 1'b1, 1'b1);
        vecs[4]  = mk(4'd10, 7'b0000010, 39'h1000, 64'd7, 64'd8, 64'h20, 39'h1004,
                      64'd0, 39'h1004, 1'b0, 1'b0);
        vecs[5]  = mk(4'd0,  7'b0011101, 39'h3000, 64'h2001, 64'd0, 64'd4, 39'h2005,
                      64'h3004, 39'h2005, 1'b1, 1'b0);
        vecs[6]  = mk(4'd1,  7'b1000000, 39'h400, 64'd0, 64'd1, 64'd0, 39'h0,
                      64'hFFFF_FFFF_FFFF_FFFF, 39'h404, 1'b0, 1'b0);
        vecs[7]  = mk(4'd4,  7'b0000000, 39'h500, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 39'h0,
                      64'd1, 39'h504, 1'b0, 1'b0);
        vecs[8]  = mk(4'd3,  7'b0000000, 39'h600, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 39'h0,
                      64'd1, 39'h604, 1'b0, 1'b0);
        vecs[9]  = mk(4'd6,  7'b1000000, 39'h700, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'd0, 39'h0,
                      64'h0000_0000_0800_0000, 39'h704, 1'b0, 1'b0);
        vecs[10] = mk(4'd2,  7'b1000000, 39'h800, 64'd1, 64'd33, 64'd0, 39'h0,
                      64'd2, 39'h804, 1'b0, 1'b0);
        vecs[11] = mk(4'd2,  7'b0000000, 39'h900, 64'd1, 64'h43, 64'd0, 39'h0,
                      64'd8, 39'h904, 1'b0, 1'b0);
        vecs[12] = mk(4'd0,  7'b0000101, 39'h7F_FFFF_FFFC, 64'd0, 64'd0, 64'd8, 39'h4,
                      64'd0, 39'h4, 1'b1, 1'b0);
        vecs[13] = mk(4'd5,  7'b0010000, 39'hA00, 64'hF0F0, 64'd0, 64'hFF, 39'hA04,
                      64'hF00F, 39'hA04, 1'b0, 1'b0);
        vecs[14] = mk(4'd13, 7'b0000010, 39'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
                      64'h40, 39'h1040, 64'd1, 39'h1040, 1'b1, 1'b0);
        vecs[15] = mk(4'd14, 7'b0000010, 39'h1000, 64'd5, 64'd3, 64'h40, 39'h2000,
                      64'd0, 39'h1004, 1'b0, 1'b1);

        #12;
        chk("reset_v_o", 128'(v_o), 128'(0));
        chk("reset_ready_o", 128'(ready_o), 128'(1));
        cmp_res("reset", '0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;

        foreach (vecs[k]) begin
            cur = vecs[k].in;
            v_i = 1'b1;
            ready_i = 1'b1;
            @(posedge clk_i);
            #1;
            v_i = 1'b0;
            lat = 1;
            while (v_o !== 1'b1 && lat < 10) begin
                @(posedge clk_i);
                #1;
                lat++;
            end
            chk("latency", 128'(lat), 128'(STAGES));
            cmp_res("vec", vecs[k].exp);
            $display("vec %0d op=%0d data=%h tgt=%h taken=%b mis=%b", k, vecs[k].in.op,
                     data_o, br_tgt_o, taken_o, mispredict_o);
            @(posedge clk_i);
            #1;
            chk("vec_empty", 128'(v_o), 128'(0));
        end

        // Three back-to-back ops, consumer stalls for 4 cycles after the first result.
        ready_i = 1'b1;
        v_i = 1'b1;
        cur = vecs[0].in;
        cyc();
        cur = vecs[3].in;
        cyc();
        cur = vecs[5].in;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_ready_o", 128'(ready_o), 128'(0));
            chk("stall_v_o", 128'(v_o), 128'(1));
            cmp_res("stall_hold", vecs[0].exp);
        end
        ready_i = 1'b1;
        cyc();
        v_i = 1'b0;
        repeat (STAGES + 3) cyc();
        chk("stall_drain", 128'(exp_q.size()), 128'(0));

        // Flush with two ops in flight and a new op presented.
        v_i = 1'b1;
        cur = vecs[3].in;
        cyc();
        cur = vecs[5].in;
        cyc();
        chk("flush_pre_v", 128'(v_o), 128'(1));
        cur = vecs[0].in;
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        v_i = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            chk("flush_v_o", 128'(v_o), 128'(0));
            cyc();
        end

        // Randomized traffic with backpressure and occasional flush.
        for (int n = 0; n < 500; n++) begin
            cur = rand_op();
            v_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 6);
            flush_i = ($urandom_range(0, 49) == 0);
            cyc();
        end
        flush_i = 1'b0;
        v_i = 1'b0;
        ready_i = 1'b1;
        repeat (STAGES + 2) cyc();
        chk("rand_drain", 128'(exp_q.size()), 128'(0));

        // Asynchronous reset during a stall.
        ready_i = 1'b0;
        v_i = 1'b1;
        cur = vecs[5].in;
        cyc();
        cyc();
        cyc();
        v_i = 1'b0;
        chk("pre_reset_v_o", 128'(v_o), 128'(1));
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("async_reset_v_o", 128'(v_o), 128'(0));
        chk("async_reset_ready_o", 128'(ready_o), 128'(1));
        cmp_res("async_reset", '0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        ready_i = 1'b1;
        v_i = 1'b1;
        cur = vecs[12].in;
        cyc();
        v_i = 1'b0;
        repeat (STAGES + 2) cyc();
        chk("post_reset_drain", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
